objf_ctrl: RTL and testbench
============================

# objf_ctrl

Sequencer and result collector for the objective/gradient engine. Captures an identity-coefficient vector, runs the engine in function or gradient mode, and collects the gradient stream (one word per element, terminated by the engine's over-flag) or the single function value. Presents the result as a held vector/word with a one-cycle done pulse. Sits between the optimizer iteration logic and the engine.

## Interface
- NUM_ELEMENTS, 50, identity coefficients / gradient words per run
- DATA_WIDTH, 64, IEEE-754 word width (data passed through, never computed on)
- RST_HOLD, 2, cycles the engine is held in reset before running (≥1)
- TIMEOUT, 4096, max cycles between engine events before abort
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  asynchronous, active-high reset
- start_grad  in  1  pulse: begin gradient run (IDLE only)
- start_func  in  1  pulse: begin function run (IDLE only)
- id_in  in  DATA_WIDTH×NUM_ELEMENTS  coefficient vector, sampled on accepted start
- busy  out  1  high from accepted start until done/err
- eng_op  out  1  engine mode: 1 gradient, 0 function
- eng_run  out  1  engine reset, active-low semantics (0 = held in reset)
- eng_id  out  DATA_WIDTH×NUM_ELEMENTS  registered copy of id_in
- eng_valid_func  in  1  function-value strobe
- eng_result_func  in  DATA_WIDTH  function value
- eng_valid_grad  in  1  gradient-word strobe
- eng_result_grad  in  DATA_WIDTH  gradient word
- eng_flagover  in  1  end-of-gradient-stream pulse
- grad_vec  out  DATA_WIDTH×NUM_ELEMENTS  collected gradient, held until next start
- func_val  out  DATA_WIDTH  collected function value, held until next start
- done  out  1  one-cycle pulse, result valid
- err  out  1  one-cycle pulse, run aborted
- err_code  out  2  0 none, 1 short stream, 2 overflow, 3 timeout; held until next start

## Operation
- Reset values: busy=0, eng_op=0, eng_run=0, eng_id=0, grad_vec=0, func_val=0, done=0, err=0, err_code=0, state IDLE.
- States: IDLE → LOAD → HOLD → RUN_GRAD | RUN_FUNC → IDLE.
- IDLE: start_grad wins if both starts high in one cycle. On accept: eng_id←id_in, eng_op set, busy=1, grad index←0, grad_vec/func_val/err_code cleared; go LOAD. Starts outside IDLE ignored.
- LOAD: eng_run=0, one cycle; go HOLD.
- HOLD: eng_run=0 for RST_HOLD cycles (counter), then eng_run=1, enter RUN state.
- RUN_GRAD: each eng_valid_grad writes grad_vec[idx]←eng_result_grad, idx++. Write when idx==NUM_ELEMENTS → err_code=2, abort. eng_flagover: idx==NUM_ELEMENTS → done; else err_code=1, abort. valid_grad and flagover in same cycle: word stored first, then flagover evaluated with updated idx. eng_valid_func ignored.
- RUN_FUNC: first eng_valid_func → func_val←eng_result_func, done. eng_valid_grad/eng_flagover ignored.
- Watchdog: counter cleared on entering RUN_* and on each accepted engine event; reaching TIMEOUT → err_code=3, abort.
- Completion/abort: done or err pulses one cycle, busy=0, eng_run=0, eng_op held, state IDLE. Results held.
- idx width: $clog2(NUM_ELEMENTS+1); saturates, never wraps.
- rst mid-run: immediate return to reset values; partial results discarded.

## Timing
- Start accepted at edge N: busy=1 and eng_id valid at N+1; eng_run rises at N+2+RST_HOLD.
- Engine event sampled at edge M: grad_vec/func_val updated at M+1; done/err asserted in cycle M+1, busy low at M+1.
- New start accepted no earlier than the cycle after done/err (IDLE re-entered).
- All outputs registered; no combinational path engine→outputs.

## Structure
- Package objf_pkg: state enum (IDLE, LOAD, HOLD, RUN_GRAD, RUN_FUNC), err_code localparams, idx-width function.
- Sub-module objf_watchdog: loadable/clearable counter with TIMEOUT compare; instantiated once.

## Test plan
- Gradient run, NUM_ELEMENTS=50, engine model emits words 1..50 then flagover → grad_vec[k]=k+1, done one pulse, err_code=0, eng_run high exactly RST_HOLD+2 cycles after start.
- Function run, engine returns 0x3FF0000000000000 after 300 cycles → func_val equals it, done pulse, grad strobes during run ignored.
- Short stream: 49 words then flagover → err pulse, err_code=1, grad_vec[48] written, grad_vec[49]=0.
- Overflow: 51 words; last word coincident with flagover → err_code=2; separately word 50 and flagover same cycle → done.
- Timeout with TIMEOUT=16: no engine events → err at 16 cycles after eng_run rise, err_code=3, eng_run=0.
- rst asserted mid RUN_GRAD after 20 words, then start_grad and start_func together → all outputs at reset values asynchronously, then gradient mode (eng_op=1) selected.

Source files
------------

// File: rtl/objf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : objf_pkg
// Description : Shared types and constants for the objective/gradient
//               engine sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package objf_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_HOLD     = 3'd2,
        S_RUN_GRAD = 3'd3,
        S_RUN_FUNC = 3'd4
    } state_t;

    localparam logic [1:0] c_ERR_NONE     = 2'd0;
    localparam logic [1:0] c_ERR_SHORT    = 2'd1;
    localparam logic [1:0] c_ERR_OVERFLOW = 2'd2;
    localparam logic [1:0] c_ERR_TIMEOUT  = 2'd3;

    // Index must be able to hold NUM_ELEMENTS itself (the "full" value).
    function automatic int idx_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/objf_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : objf_ctrl_if
// Description : Optimizer-side and engine-side signals of the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface objf_ctrl_if #(
    parameter int NUM_ELEMENTS = 50,
    parameter int DATA_WIDTH   = 64
);
    logic                                    start_grad;
    logic                                    start_func;
    logic [NUM_ELEMENTS-1:0][DATA_WIDTH-1:0] id_in;
    logic                                    busy;
    logic                                    eng_op;
    logic                                    eng_run;
    logic [NUM_ELEMENTS-1:0][DATA_WIDTH-1:0] eng_id;
    logic                                    eng_valid_func;
    logic [DATA_WIDTH-1:0]                   eng_result_func;
    logic                                    eng_valid_grad;
    logic [DATA_WIDTH-1:0]                   eng_result_grad;
    logic                                    eng_flagover;
    logic [NUM_ELEMENTS-1:0][DATA_WIDTH-1:0] grad_vec;
    logic [DATA_WIDTH-1:0]                   func_val;
    logic                                    done;
    logic                                    err;
    logic [1:0]                              err_code;

    modport master (
        input  start_grad, start_func, id_in,
        input  eng_valid_func, eng_result_func, eng_valid_grad, eng_result_grad, eng_flagover,
        output busy, eng_op, eng_run, eng_id, grad_vec, func_val, done, err, err_code
    );

    modport slave (
        output start_grad, start_func, id_in,
        output eng_valid_func, eng_result_func, eng_valid_grad, eng_result_grad, eng_flagover,
        input  busy, eng_op, eng_run, eng_id, grad_vec, func_val, done, err, err_code
    );
endinterface
`default_nettype wire

// File: rtl/objf_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : objf_watchdog
// Description : Clearable inactivity counter flagging the cycle on which
//               TIMEOUT idle cycles would be reached.
// Revision    : 1.0 - initial release
// ============================================================================
module objf_watchdog #(
    parameter int TIMEOUT = 4096
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_clr,
    input  wire logic i_en,
    output logic      o_expired
);
    localparam int                 c_CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(TIMEOUT - 1);

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != c_LAST)) begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    // A clearing event in the same cycle always beats expiry.
    assign o_expired = i_en && !i_clr && (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/objf_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : objf_ctrl
// Description : Sequences the objective/gradient engine and collects its
//               function value or gradient stream into held result registers.
// Revision    : 1.0 - initial release
// ============================================================================
module objf_ctrl
    import objf_pkg::*;
#(
    parameter int NUM_ELEMENTS = 50,
    parameter int DATA_WIDTH   = 64,
    parameter int RST_HOLD     = 2,
    parameter int TIMEOUT      = 4096
) (
    input  wire logic   clk,
    input  wire logic   rst,
    objf_ctrl_if.master bus
);
    localparam int c_IDX_W  = idx_width(NUM_ELEMENTS);
    localparam int c_HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    localparam logic [c_IDX_W-1:0]  c_IDX_FULL  = c_IDX_W'(NUM_ELEMENTS);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(RST_HOLD - 1);

    state_t                                  r_state;
    logic [c_HOLD_W-1:0]                     r_hold_cnt;
    logic [c_IDX_W-1:0]                      r_idx;
    logic                                    r_busy;
    logic                                    r_eng_op;
    logic                                    r_eng_run;
    logic                                    r_done;
    logic                                    r_err;
    logic [1:0]                              r_err_code;
    logic [NUM_ELEMENTS-1:0][DATA_WIDTH-1:0] r_eng_id;
    logic [NUM_ELEMENTS-1:0][DATA_WIDTH-1:0] r_grad_vec;
    logic [DATA_WIDTH-1:0]                   r_func_val;

    logic               w_run;
    logic               w_grad_event;
    logic               w_func_event;
    logic               w_wd_clr;
    logic               w_wd_expired;
    logic               w_grad_wr;
    logic               w_grad_ovf;
    logic [c_IDX_W-1:0] w_idx_upd;

    assign w_run        = (r_state == S_RUN_GRAD) || (r_state == S_RUN_FUNC);
    assign w_grad_event = (r_state == S_RUN_GRAD) && (bus.eng_valid_grad || bus.eng_flagover);
    assign w_func_event = (r_state == S_RUN_FUNC) && bus.eng_valid_func;
    assign w_wd_clr     = !w_run || w_grad_event || w_func_event;

    // Flagover is judged against the index after this cycle's word is stored.
    assign w_grad_wr  = bus.eng_valid_grad && (r_idx != c_IDX_FULL);
    assign w_grad_ovf = bus.eng_valid_grad && (r_idx == c_IDX_FULL);
    assign w_idx_upd  = w_grad_wr ? (r_idx + c_IDX_W'(1)) : r_idx;

    objf_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_wd_clr),
        .i_en      (w_run),
        .o_expired (w_wd_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_hold_cnt <= '0;
            r_idx      <= '0;
            r_busy     <= 1'b0;
            r_eng_op   <= 1'b0;
            r_eng_run  <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= c_ERR_NONE;
            r_eng_id   <= '0;
            r_grad_vec <= '0;
            r_func_val <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start_grad || bus.start_func) begin
                        r_eng_id   <= bus.id_in;
                        r_eng_op   <= bus.start_grad;
                        r_busy     <= 1'b1;
                        r_idx      <= '0;
                        r_grad_vec <= '0;
                        r_func_val <= '0;
                        r_err_code <= c_ERR_NONE;
                        r_state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_hold_cnt <= '0;
                    r_state    <= S_HOLD;
                end
                S_HOLD: begin
                    if (r_hold_cnt == c_HOLD_LAST) begin
                        r_eng_run <= 1'b1;
                        r_state   <= r_eng_op ? S_RUN_GRAD : S_RUN_FUNC;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + c_HOLD_W'(1);
                    end
                end
                S_RUN_GRAD: begin
                    if (w_grad_wr) begin
                        r_grad_vec[r_idx] <= bus.eng_result_grad;
                        r_idx             <= w_idx_upd;
                    end
                    if (w_grad_ovf) begin
                        r_err      <= 1'b1;
                        r_err_code <= c_ERR_OVERFLOW;
                        r_busy     <= 1'b0;
                        r_eng_run  <= 1'b0;
                        r_state    <= S_IDLE;
                    end else if (bus.eng_flagover) begin
                        if (w_idx_upd == c_IDX_FULL) begin
                            r_done <= 1'b1;
                        end else begin
                            r_err      <= 1'b1;
                            r_err_code <= c_ERR_SHORT;
                        end
                        r_busy    <= 1'b0;
                        r_eng_run <= 1'b0;
                        r_state   <= S_IDLE;
                    end else if (w_wd_expired) begin
                        r_err      <= 1'b1;
                        r_err_code <= c_ERR_TIMEOUT;
                        r_busy     <= 1'b0;
                        r_eng_run  <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                S_RUN_FUNC: begin
                    if (bus.eng_valid_func) begin
                        r_func_val <= bus.eng_result_func;
                        r_done     <= 1'b1;
                        r_busy     <= 1'b0;
                        r_eng_run  <= 1'b0;
                        r_state    <= S_IDLE;
                    end else if (w_wd_expired) begin
                        r_err      <= 1'b1;
                        r_err_code <= c_ERR_TIMEOUT;
                        r_busy     <= 1'b0;
                        r_eng_run  <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.eng_op   = r_eng_op;
    assign bus.eng_run  = r_eng_run;
    assign bus.eng_id   = r_eng_id;
    assign bus.grad_vec = r_grad_vec;
    assign bus.func_val = r_func_val;
    assign bus.done     = r_done;
    assign bus.err      = r_err;
    assign bus.err_code = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_objf_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_objf_ctrl
// Description : Randomized scoreboard bench for objf_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_objf_ctrl;
    import objf_pkg::*;

    localparam int N  = 50;
    localparam int W  = 64;
    localparam int RH = 2;
    localparam int TO = 400;

    typedef logic [N-1:0][W-1:0] vec_t;
    typedef struct {
        bit         is_err;
        logic [1:0] code;
        bit         op;
        vec_t       vec;
        logic [W-1:0] fval;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    objf_ctrl_if #(.NUM_ELEMENTS(N), .DATA_WIDTH(W)) bus ();

    objf_ctrl #(
        .NUM_ELEMENTS (N),
        .DATA_WIDTH   (W),
        .RST_HOLD     (RH),
        .TIMEOUT      (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int           n_cmp  = 0;
    int           n_fail = 0;
    exp_t         sb[$];
    logic [W-1:0] wbuf [0:N+1];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    task automatic check_vec(input string name, input vec_t act, input vec_t req);
        int bad;
        bad = -1;
        n_cmp++;
        for (int i = N - 1; i >= 0; i--)
            if (act[i] !== req[i]) bad = i;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h, want %h", name, bad, act[bad], req[bad]);
        end
    endtask

    function automatic logic [W-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic vec_t rnd_vec();
        vec_t v;
        for (int i = 0; i < N; i++) v[i] = rnd64();
        return v;
    endfunction

    // Reference: a stream of nwords words, flagover after the last one.
    function automatic exp_t model_grad(input int nwords);
        exp_t e;
        e.op   = 1'b1;
        e.fval = '0;
        e.vec  = '0;
        for (int i = 0; i < nwords && i < N; i++) e.vec[i] = wbuf[i];
        if (nwords > N) begin
            e.is_err = 1'b1; e.code = 2'd2;
        end else if (nwords == N) begin
            e.is_err = 1'b0; e.code = 2'd0;
        end else begin
            e.is_err = 1'b1; e.code = 2'd1;
        end
        return e;
    endfunction

    // Monitor: every done/err pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && (bus.done || bus.err)) begin
            exp_t e;
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_result: done=%0b err=%0b, none outstanding", bus.done, bus.err);
            end else begin
                e = sb.pop_front();
                check("result_kind", {bus.done, bus.err}, e.is_err ? 2'b01 : 2'b10);
                check("err_code", bus.err_code, e.code);
                check("eng_op_at_end", bus.eng_op, e.op);
                check("busy_at_end", bus.busy, 1'b0);
                check("eng_run_at_end", bus.eng_run, 1'b0);
                check("func_val", bus.func_val, e.fval);
                check_vec("grad_vec", bus.grad_vec, e.vec);
            end
        end
    end

    task automatic idle_inputs();
        bus.start_grad      = 1'b0;
        bus.start_func      = 1'b0;
        bus.id_in           = '0;
        bus.eng_valid_func  = 1'b0;
        bus.eng_result_func = '0;
        bus.eng_valid_grad  = 1'b0;
        bus.eng_result_grad = '0;
        bus.eng_flagover    = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, bus.busy, 1'b0);
        check({tag, "_eng_op"}, bus.eng_op, 1'b0);
        check({tag, "_eng_run"}, bus.eng_run, 1'b0);
        check({tag, "_done"}, bus.done, 1'b0);
        check({tag, "_err"}, bus.err, 1'b0);
        check({tag, "_err_code"}, bus.err_code, 2'd0);
        check({tag, "_func_val"}, bus.func_val, '0);
        check_vec({tag, "_eng_id"}, bus.eng_id, '0);
        check_vec({tag, "_grad_vec"}, bus.grad_vec, '0);
    endtask

    // One engine event lasting exactly one cycle; called and returns on a negedge.
    task automatic eng_event(input bit vg, input logic [W-1:0] gd, input bit fo,
                             input bit vf, input logic [W-1:0] fd);
        bus.start_grad      = 1'b0;
        bus.start_func      = 1'b0;
        bus.eng_valid_grad  = vg;
        bus.eng_result_grad = gd;
        bus.eng_flagover    = fo;
        bus.eng_valid_func  = vf;
        bus.eng_result_func = fd;
        @(negedge clk);
        bus.eng_valid_grad  = 1'b0;
        bus.eng_flagover    = 1'b0;
        bus.eng_valid_func  = 1'b0;
    endtask

    task automatic start_run(input bit grad, input bit both);
        vec_t ids;
        int   k;
        ids = rnd_vec();
        @(negedge clk);
        bus.id_in      = ids;
        bus.start_grad = grad | both;
        bus.start_func = ~grad | both;
        @(negedge clk);
        bus.start_grad = 1'b0;
        bus.start_func = 1'b0;
        check("busy_after_start", bus.busy, 1'b1);
        check("eng_op_after_start", bus.eng_op, grad | both);
        check_vec("eng_id_capture", bus.eng_id, ids);
        bus.id_in = rnd_vec();
        k = 1;
        while (!bus.eng_run && k < RH + 10) begin
            @(negedge clk);
            k++;
        end
        check("eng_run_latency", k, RH + 2);
        check_vec("eng_id_held", bus.eng_id, ids);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (bus.busy && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("returns_idle", bus.busy, 1'b0);
        @(negedge clk);
    endtask

    task automatic grad_run(input int nwords, input bit flag_last, input bit both, input bit seq);
        bit fl;
        fl = flag_last && (nwords > 0);
        for (int i = 0; i < nwords; i++) wbuf[i] = seq ? W'(i + 1) : rnd64();
        sb.push_back(model_grad(nwords));
        start_run(1'b1, both);
        for (int i = 0; i < nwords; i++) begin
            repeat ($urandom_range(0, 2)) begin
                bus.eng_valid_func  = 1'($urandom_range(0, 1));
                bus.eng_result_func = rnd64();
                bus.start_grad      = ($urandom_range(0, 5) == 0);
                bus.start_func      = ($urandom_range(0, 5) == 0);
                @(negedge clk);
            end
            eng_event(1'b1, wbuf[i], fl && (i == nwords - 1), 1'b0, '0);
        end
        if (!fl) eng_event(1'b0, '0, 1'b1, 1'b0, '0);
        wait_idle();
    endtask

    task automatic func_run(input int delay, input logic [W-1:0] val);
        exp_t e;
        e.is_err = 1'b0; e.code = 2'd0; e.op = 1'b0; e.vec = '0; e.fval = val;
        sb.push_back(e);
        start_run(1'b0, 1'b0);
        repeat (delay) begin
            bus.eng_valid_grad  = 1'($urandom_range(0, 1));
            bus.eng_result_grad = rnd64();
            bus.eng_flagover    = ($urandom_range(0, 7) == 0);
            @(negedge clk);
        end
        eng_event(1'b0, '0, 1'b0, 1'b1, val);
        wait_idle();
    endtask

    task automatic timeout_run(input bit grad);
        exp_t e;
        int   k;
        e.is_err = 1'b1; e.code = 2'd3; e.op = grad; e.vec = '0; e.fval = '0;
        sb.push_back(e);
        start_run(grad, 1'b0);
        k = 0;
        while (!bus.err && k < TO + 20) begin
            // Events belonging to the other mode must not feed the watchdog.
            bus.eng_valid_func = grad & 1'($urandom_range(0, 1));
            bus.eng_valid_grad = ~grad & 1'($urandom_range(0, 1));
            bus.eng_flagover   = ~grad & ($urandom_range(0, 7) == 0);
            @(negedge clk);
            k++;
        end
        bus.eng_valid_func = 1'b0;
        bus.eng_valid_grad = 1'b0;
        bus.eng_flagover   = 1'b0;
        check("timeout_latency", k, TO);
        wait_idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit: bench still running, want completion");
        $fatal(1, "time limit");
    end

    initial begin
        idle_inputs();
        repeat (3) @(negedge clk);
        check_reset_values("reset_held");
        rst = 1'b0;
        @(negedge clk);
        check_reset_values("reset_released");

        grad_run(N, 1'b0, 1'b0, 1'b1);
        func_run(300, 64'h3FF0_0000_0000_0000);
        grad_run(N - 1, 1'b0, 1'b0, 1'b0);
        grad_run(N + 1, 1'b1, 1'b0, 1'b0);
        grad_run(N, 1'b1, 1'b0, 1'b0);
        grad_run(0, 1'b0, 1'b0, 1'b0);
        timeout_run(1'b1);
        timeout_run(1'b0);

        for (int r = 0; r < 12; r++) begin
            case ($urandom_range(0, 2))
                0: grad_run($urandom_range(N - 2, N + 1), 1'($urandom_range(0, 1)),
                            1'($urandom_range(0, 1)), 1'b0);
                1: func_run($urandom_range(0, 150), rnd64());
                default: grad_run(N, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
            endcase
        end

        // Asynchronous reset partway through a gradient stream.
        for (int i = 0; i < 20; i++) wbuf[i] = rnd64();
        start_run(1'b1, 1'b0);
        for (int i = 0; i < 20; i++) eng_event(1'b1, wbuf[i], 1'b0, 1'b0, '0);
        #2 rst = 1'b1;
        #1;
        check_reset_values("async_reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        grad_run(N, 1'b1, 1'b1, 1'b0);

        check("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
